// File: rtl/squ_ker_wr_addr_gen.sv
// Squeeze-kernel write address generator: normal sweep plus optional double-window repeat sweep.
// Optional abort input is compiled in when SQU_WR_ABORT_EN is defined.
module squ_ker_wr_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int LAYR_W = 6,
  parameter int REP_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              repeat_en_i,
  input  logic [ADDR_W-1:0] tot_addr_limit_i,
  input  logic [LAYR_W-1:0] one_ker_addr_limit_i,
  input  logic [REP_W-1:0]  tot_repeat_i,
  input  logic              wr_valid_i,
`ifdef SQU_WR_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              wr_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              layr_last_o,
  output logic              repeat_flag_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [LAYR_W:0]   layr_cnt_q, layr_cnt_d;
  logic [REP_W-1:0]  win_cnt_q, win_cnt_d;
  logic [ADDR_W-1:0] tot_lim_q, tot_lim_d;
  logic [LAYR_W-1:0] one_ker_q, one_ker_d;
  logic [REP_W-1:0]  tot_rep_q, tot_rep_d;
  logic              rep_en_q, rep_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              layr_last_q, layr_last_d;
  logic              repeat_flag_q, repeat_flag_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic              abort_s;
  logic              beat_s;
  logic              addr_end_s;
  logic              layr_end_s;
  logic [LAYR_W:0]   layr_lim_s;

`ifdef SQU_WR_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  assign beat_s     = wr_valid_i & ready_q;
  assign addr_end_s = (addr_cnt_q == tot_lim_q);
  assign layr_end_s = (layr_cnt_q == layr_lim_s);

  // Layer window limit; the repeat window is twice as long and needs the extra bit
  always_comb begin
    layr_lim_s = {1'b0, one_ker_q} - {{LAYR_W{1'b0}}, 1'b1};
    if (state_q == ST_REPEAT) begin
      layr_lim_s = {one_ker_q, 1'b0} - {{LAYR_W{1'b0}}, 1'b1};
    end else begin
      layr_lim_s = {1'b0, one_ker_q} - {{LAYR_W{1'b0}}, 1'b1};
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d       = state_q;
    addr_cnt_d    = addr_cnt_q;
    layr_cnt_d    = layr_cnt_q;
    win_cnt_d     = win_cnt_q;
    tot_lim_d     = tot_lim_q;
    one_ker_d     = one_ker_q;
    tot_rep_d     = tot_rep_q;
    rep_en_d      = rep_en_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    layr_last_d   = 1'b0;
    repeat_flag_d = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (one_ker_addr_limit_i == {LAYR_W{1'b0}}) begin
            cfg_err_d = 1'b1;
          end else begin
            tot_lim_d  = tot_addr_limit_i;
            one_ker_d  = one_ker_addr_limit_i;
            tot_rep_d  = tot_repeat_i;
            rep_en_d   = repeat_en_i;
            addr_cnt_d = {ADDR_W{1'b0}};
            layr_cnt_d = {(LAYR_W+1){1'b0}};
            win_cnt_d  = {REP_W{1'b0}};
            state_d    = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (abort_s) begin
          addr_cnt_d = {ADDR_W{1'b0}};
          layr_cnt_d = {(LAYR_W+1){1'b0}};
          win_cnt_d  = {REP_W{1'b0}};
          state_d    = ST_IDLE;
        end else if (beat_s) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_cnt_q;
          layr_last_d = layr_end_s | addr_end_s;
          if (addr_end_s) begin
            if (rep_en_q && (tot_rep_q != {REP_W{1'b0}})) begin
              addr_cnt_d    = {ADDR_W{1'b0}};
              layr_cnt_d    = {(LAYR_W+1){1'b0}};
              win_cnt_d     = {REP_W{1'b0}};
              repeat_flag_d = 1'b1;
              state_d       = ST_REPEAT;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            addr_cnt_d = addr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            layr_cnt_d = layr_end_s ? {(LAYR_W+1){1'b0}}
                                    : layr_cnt_q + {{LAYR_W{1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_REPEAT: begin
        if (abort_s) begin
          addr_cnt_d = {ADDR_W{1'b0}};
          layr_cnt_d = {(LAYR_W+1){1'b0}};
          win_cnt_d  = {REP_W{1'b0}};
          state_d    = ST_IDLE;
        end else if (beat_s) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_cnt_q;
          layr_last_d = layr_end_s;
          addr_cnt_d  = addr_end_s ? {ADDR_W{1'b0}}
                                   : addr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (layr_end_s) begin
            layr_cnt_d = {(LAYR_W+1){1'b0}};
            if (win_cnt_q == (tot_rep_q - {{(REP_W-1){1'b0}}, 1'b1})) begin
              state_d = ST_DONE;
            end else begin
              win_cnt_d = win_cnt_q + {{(REP_W-1){1'b0}}, 1'b1};
            end
          end else begin
            layr_cnt_d = layr_cnt_q + {{LAYR_W{1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_REPEAT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_WRITE) || (state_d == ST_REPEAT);
    busy_d  = ready_d;
  end

  // State, counter, configuration and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      addr_cnt_q    <= {ADDR_W{1'b0}};
      layr_cnt_q    <= {(LAYR_W+1){1'b0}};
      win_cnt_q     <= {REP_W{1'b0}};
      tot_lim_q     <= {ADDR_W{1'b0}};
      one_ker_q     <= {LAYR_W{1'b0}};
      tot_rep_q     <= {REP_W{1'b0}};
      rep_en_q      <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= {ADDR_W{1'b0}};
      layr_last_q   <= 1'b0;
      repeat_flag_q <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_cnt_q    <= addr_cnt_d;
      layr_cnt_q    <= layr_cnt_d;
      win_cnt_q     <= win_cnt_d;
      tot_lim_q     <= tot_lim_d;
      one_ker_q     <= one_ker_d;
      tot_rep_q     <= tot_rep_d;
      rep_en_q      <= rep_en_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      layr_last_q   <= layr_last_d;
      repeat_flag_q <= repeat_flag_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign wr_ready_o    = ready_q;
  assign busy_o        = busy_q;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign layr_last_o   = layr_last_q;
  assign repeat_flag_o = repeat_flag_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_squ_ker_wr_addr_gen.sv
// Scoreboard bench for squ_ker_wr_addr_gen: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_squ_ker_wr_addr_gen;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_REP  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        repeat_en_i = 1'b0;
  logic [11:0] tot_addr_limit_i = 12'd0;
  logic [5:0]  one_ker_addr_limit_i = 6'd0;
  logic [15:0] tot_repeat_i = 16'd0;
  logic        wr_valid_i = 1'b0;
`ifdef SQU_WR_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  logic        wr_ready_o, wr_en_o, layr_last_o, repeat_flag_o, busy_o, done_o, cfg_err_o;
  logic [11:0] wr_addr_o;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tmo_cnt = 0;
  int   tmo_seen = 0;
  logic mon_en = 1'b0;
  logic [1:0] quiet_mode = 2'd0;
  logic prev_acc = 1'b0;

  squ_ker_wr_addr_gen dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .start_i              (start_i),
    .repeat_en_i          (repeat_en_i),
    .tot_addr_limit_i     (tot_addr_limit_i),
    .one_ker_addr_limit_i (one_ker_addr_limit_i),
    .tot_repeat_i         (tot_repeat_i),
    .wr_valid_i           (wr_valid_i),
`ifdef SQU_WR_ABORT_EN
    .abort_i              (abort_i),
`endif
    .wr_ready_o           (wr_ready_o),
    .wr_en_o              (wr_en_o),
    .wr_addr_o            (wr_addr_o),
    .layr_last_o          (layr_last_o),
    .repeat_flag_o        (repeat_flag_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .cfg_err_o            (cfg_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor (sole owner of checks/errors) ----------------
  task automatic cmp_ev(input logic [1:0] k, input logic [11:0] a, input logic l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d last=%0b at %0t, required no event", k, a, l, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_WR && (e.addr != a || e.last != l))) begin
        errors++;
        $display("FAIL event_seq: got kind=%0d addr=%0d last=%0b at %0t, required kind=%0d addr=%0d last=%0b",
                 k, a, l, $time, e.kind, e.addr, e.last);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tmo_cnt != tmo_seen) begin
      checks++;
      errors++;
      tmo_seen = tmo_cnt;
    end
    if (mon_en) begin
      if (quiet_mode == 2'd1) begin
        checks++;
        if ({wr_en_o, wr_addr_o, layr_last_o, repeat_flag_o, busy_o, done_o, cfg_err_o, wr_ready_o} !== 19'd0) begin
          errors++;
          $display("FAIL quiet_all: got en=%b addr=%0d last=%b rep=%b busy=%b done=%b err=%b rdy=%b, required all 0",
                   wr_en_o, wr_addr_o, layr_last_o, repeat_flag_o, busy_o, done_o, cfg_err_o, wr_ready_o);
        end
      end else if (quiet_mode == 2'd2) begin
        checks++;
        if ({wr_en_o, layr_last_o, repeat_flag_o, busy_o, done_o, cfg_err_o, wr_ready_o} !== 7'd0) begin
          errors++;
          $display("FAIL quiet_idle: got en=%b last=%b rep=%b busy=%b done=%b err=%b rdy=%b, required all 0",
                   wr_en_o, layr_last_o, repeat_flag_o, busy_o, done_o, cfg_err_o, wr_ready_o);
        end
      end
      if (!prev_acc) begin
        checks++;
        if (wr_en_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_wr_en: got wr_en_o=%b at %0t after non-accepted cycle, required 0", wr_en_o, $time);
        end
      end
      if (wr_en_o === 1'b1)       cmp_ev(EV_WR, wr_addr_o, layr_last_o);
      if (repeat_flag_o === 1'b1) cmp_ev(EV_REP, 12'd0, 1'b0);
      if (done_o === 1'b1)        cmp_ev(EV_DONE, 12'd0, 1'b0);
      if (cfg_err_o === 1'b1)     cmp_ev(EV_ERR, 12'd0, 1'b0);
`ifdef SQU_WR_ABORT_EN
      prev_acc = wr_valid_i & wr_ready_o & ~rst_i & ~abort_i;
`else
      prev_acc = wr_valid_i & wr_ready_o & ~rst_i;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [1:0] k, input int a, input logic l);
    ev_t e;
    e.kind = k;
    e.addr = a[11:0];
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Expected event stream of a full run, written from the sweep description
  task automatic push_sweep(input int tot, input int one, input bit ren, input int trep);
    int cnt;
    for (int a = 0; a <= tot; a++) push(EV_WR, a, ((a % one) == one - 1) || (a == tot));
    if (ren && trep != 0) begin
      push(EV_REP, 0, 1'b0);
      cnt = 0;
      for (int w = 0; w < trep; w++) begin
        for (int k = 0; k < 2 * one; k++) begin
          push(EV_WR, cnt, k == 2 * one - 1);
          cnt = (cnt == tot) ? 0 : cnt + 1;
        end
      end
    end
    push(EV_DONE, 0, 1'b0);
  endtask

  task automatic do_start(input logic [11:0] tot, input logic [5:0] one, input logic ren, input logic [15:0] trep);
    @(posedge clk); #1;
    tot_addr_limit_i     = tot;
    one_ker_addr_limit_i = one;
    repeat_en_i          = ren;
    tot_repeat_i         = trep;
    start_i              = 1'b1;
    @(posedge clk); #1;
    start_i              = 1'b0;
    tot_addr_limit_i     = 12'd5;
    one_ker_addr_limit_i = 6'd0;
    repeat_en_i          = ~ren;
    tot_repeat_i         = 16'd9;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_%s: %0d expected events outstanding, required 0", name, exp_q.size());
      tmo_cnt++;
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_addr4(input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (wr_en_o === 1'b1 && wr_addr_o == 12'd4) hit = 1'b1;
    end
    if (!hit) begin
      $display("FAIL wait_%s: addr-4 write not seen within budget, required seen", name);
      tmo_cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst_i  = 1'b0;
    quiet_mode = 2'd1;
    repeat (10) @(posedge clk);
    #1;
    quiet_mode = 2'd0;

    // plain sweep, valid held high (also covers start+valid in the same IDLE cycle)
    wr_valid_i = 1'b1;
    push_sweep(7, 2, 1'b0, 0);
    do_start(12'd7, 6'd2, 1'b0, 16'd0);
    drain("plain");

    // normal sweep followed by three repeat windows
    push_sweep(3, 2, 1'b1, 3);
    do_start(12'd3, 6'd2, 1'b1, 16'd3);
    drain("repeat");

    // valid toggling 1,0,0,1 with a rejected-looking start mid-sweep
    wr_valid_i = 1'b0;
    push_sweep(7, 2, 1'b0, 0);
    do_start(12'd7, 6'd2, 1'b0, 16'd0);
    for (int i = 0; i < 40; i++) begin
      wr_valid_i = pat[i % 4];
      start_i = (i == 6);
      if (i == 6) one_ker_addr_limit_i = 6'd0;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    drain("toggle");

    // one_ker == 0 is rejected, block stays idle
    wr_valid_i = 1'b1;
    push(EV_ERR, 0, 1'b0);
    do_start(12'd7, 6'd0, 1'b0, 16'd0);
    drain("cfg_err");
    quiet_mode = 2'd2;
    repeat (4) @(posedge clk);
    #1;
    quiet_mode = 2'd0;

    // repeat enabled with zero windows: no repeat flag
    push_sweep(1, 1, 1'b1, 0);
    do_start(12'd1, 6'd1, 1'b1, 16'd0);
    drain("rep_zero");

    // single-beat sweep
    push_sweep(0, 3, 1'b0, 0);
    do_start(12'd0, 6'd3, 1'b0, 16'd0);
    drain("single");

    // widest window: 2*63-1 = 125
    push_sweep(127, 63, 1'b1, 1);
    do_start(12'd127, 6'd63, 1'b1, 16'd1);
    drain("wide");

    // reset at the addr-4 write
    for (int a = 0; a <= 4; a++) push(EV_WR, a, (a % 2) == 1);
    do_start(12'd7, 6'd2, 1'b0, 16'd0);
    wait_addr4("reset");
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    quiet_mode = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    quiet_mode = 2'd0;
    drain("reset");

`ifdef SQU_WR_ABORT_EN
    // abort at the addr-4 write, then a fresh run from address 0
    for (int a = 0; a <= 4; a++) push(EV_WR, a, (a % 2) == 1);
    do_start(12'd7, 6'd2, 1'b0, 16'd0);
    wait_addr4("abort");
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    quiet_mode = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    quiet_mode = 2'd0;
    drain("abort");
    push_sweep(7, 2, 1'b0, 0);
    do_start(12'd7, 6'd2, 1'b0, 16'd0);
    drain("rerun");
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
